// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit path: issue-FSM encodings and the byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer handshake plus transmitter launch signals of the uart tx fifo.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
) ();

    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] tx_din;
    logic              tx_wr_en;
    logic              tx_busy;

    // master is the environment (producer + transmitter); slave is the fifo
    modport master (
        output wr_data, wr_valid, tx_busy,
        input  wr_ready, tx_din, tx_wr_en
    );

    modport slave (
        input  wr_data, wr_valid, tx_busy,
        output wr_ready, tx_din, tx_wr_en
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Byte storage for the tx fifo: one write port and one registered read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the transmitter data hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and issue controller feeding the uart transmitter one byte per idle period.
// Optional UART_TX_FIFO_STATS_EN adds a saturating overflow-drop counter (ovf_clr/ovf_cnt).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W,
    parameter int BUSY_TO    = 4
) (
    input  logic                clk_50m,
    input  logic                rst,
    uart_tx_fifo_if.slave       bus,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
`ifdef UART_TX_FIFO_STATS_EN
    ,
    input  logic                ovf_clr,
    output logic [7:0]          ovf_cnt
`endif
);

    localparam logic [7:0] BTO_LAST = 8'(BUSY_TO - 1);

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [7:0]          bto_cnt;
    logic                push;
    logic                launch;
    logic                tx_wr_en;
    logic [DATA_W-1:0]   tx_din;
    tx_state_t           state;
    tx_state_t           state_nx;

    // Extra wrap bit distinguishes full from empty when the indices match
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign push  = bus.wr_valid && !full;

    assign bus.wr_ready = !full;
    assign bus.tx_wr_en = tx_wr_en;
    assign bus.tx_din   = tx_din;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .clk     (clk_50m),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (launch),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (tx_din)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state    <= IDLE;
            tx_wr_en <= 1'b0;
            bto_cnt  <= '0;
        end else begin
            state    <= state_nx;
            tx_wr_en <= launch;
            bto_cnt  <= (state == WAIT_BUSY) ? bto_cnt + 8'd1 : 8'd0;
        end
    end

    // A transmitter that never raises busy must not stall the queue forever
    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    launch   = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (bto_cnt == BTO_LAST) begin
                    state_nx = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef UART_TX_FIFO_STATS_EN
    always_ff @(posedge clk_50m) begin
        if (rst || ovf_clr) begin
            ovf_cnt <= '0;
        end else if (bus.wr_valid && full && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule
